sqrt_arbiter: RTL
=================

Name: sqrt_arbiter

Overview:
- Shares one SquareRootModule datapath among N_REQ requesters using round-robin arbitration.
- Latches the winner's radicand, pulses the core's start input and waits for the core's valid.
- Returns the root to the winner with a one-cycle done pulse.
- Sits between the client blocks and the single sqrt core instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, radicand width (even).
- RES_W, WIDTH/2, root width.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  N_REQ  per-requester request level.
- radicand_i  in  N_REQ*WIDTH  packed radicands; slice k is [k*WIDTH +: WIDTH].
- grant_o  out  N_REQ  one-hot, asserted from ISSUE through DELIVER for the current owner.
- done_o  out  N_REQ  one-hot, one-cycle pulse when the result is valid.
- result_o  out  RES_W  root; valid only while done_o is nonzero.
- busy_o  out  1  high whenever the state is not IDLE.
- core_s_o  out  WIDTH  radicand driven to the core, held stable ISSUE..WAIT.
- core_doSqrt_o  out  1  start pulse to the core.
- core_valid_i  in  1  core result valid.
- core_sqrt_i  in  RES_W  core result.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, rr pointer=0, and grant_o, done_o, result_o, core_s_o, core_doSqrt_o, busy_o all 0.
- Reset mid-operation aborts. No done_o pulse is produced. The core is not signalled; its late core_valid_i is ignored because it arrives in IDLE.
- FSM:
  - IDLE: if any req_i bit is set, pick the first set bit at or after the pointer (wrapping from N_REQ-1 to 0). Latch the index and radicand into core_s_o. Set pointer = winner+1 mod N_REQ. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: core_doSqrt_o=1 for exactly this cycle; go to WAIT. core_valid_i is ignored here.
  - WAIT: on core_valid_i=1, capture core_sqrt_i into result_o and go to DELIVER.
  - DELIVER: done_o[owner]=1 for one cycle, then clear grant and go to IDLE.
- Latency: req seen in IDLE at edge t gives ISSUE at t+1 and WAIT at t+2. core_valid_i at edge v gives DELIVER (done) during cycle v+1 and IDLE at v+2.
- Minimum gap between grants is one IDLE cycle.
- Handshake rules:
  - A requester holds req_i and its radicand until its done_o pulse.
  - The radicand is sampled only at the grant edge; later changes are ignored.
  - Dropping req_i after grant does not abort; done_o still pulses and the result may be ignored.
  - req_i still high after done_o is re-arbitrated normally. The rr pointer has already moved past the winner, so other pending requesters win first.
- Boundaries:
  - Radicand 0 gives result 0.
  - Radicand 2^WIDTH-1 gives 2^RES_W-1; the arbiter passes core_sqrt_i through unmodified.
  - When all requesters are asserted, service order is strictly cyclic.
  - A single requester toggling req_i every done_o is served back-to-back, one IDLE cycle apart.
- result_o holds its last value between operations (registered), but consumers use it only with done_o.

Optional Feature:
- SQRT_TIMEOUT_EN: adds a localparam TIMEOUT_CYC=64, a watchdog counter and an output port err_o (1 bit).
- With SQRT_TIMEOUT_EN:
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without core_valid_i: result_o=0, err_o=1 for the DELIVER cycle, then the normal done_o pulse.
  - err_o resets to 0.
- Without SQRT_TIMEOUT_EN: no port, no counter; WAIT waits indefinitely.

Decomposition:
- Package sqrt_pkg:
  - state enum (IDLE, ISSUE, WAIT, DELIVER; 2 bits);
  - default WIDTH and RES_W constants;
  - TIMEOUT_CYC.
- Sub-module rr_picker: combinational. Inputs are req vector and pointer; outputs are one-hot grant and a found flag. Parameterised by N_REQ.

Test Plan:
- Single request: req_i[2]=1, radicand 144, core model valid 5 cycles after doSqrt. Expect core_s_o=144, doSqrt high for exactly one cycle, done_o=4'b0100, result_o=12, busy_o low 2 cycles after valid.
- Simultaneous requests: all four requests at once, radicands 1, 4, 9, 16, pointer=0. Expect done order 0,1,2,3 with results 1,2,3,4 and each grant one-hot.
- Fairness: req0 held high continuously plus req3 asserted. Expect grants alternating 0,3,0,3 and no starvation.
- Reset mid-operation: rst_i in WAIT, then core_valid_i arrives 2 cycles later. Expect no done_o, all outputs 0, and the next request served normally from pointer 0.
- Extremes: radicand 0 gives 0; radicand 0xFFFFFFFF gives 0xFFFF. Radicand changed after grant: the latched value is still used.
- Timeout: with SQRT_TIMEOUT_EN, the core never asserts valid. Expect done_o and err_o=1 with result_o=0 at WAIT cycle 64; err_o=0 on the following normal operation.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the round-robin square-root arbiter.
package sqrt_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_DELIVER = 2'd3
   } state_e;

   localparam int SQRT_WIDTH  = 32;
   localparam int SQRT_RES_W  = SQRT_WIDTH / 2;
   localparam int TIMEOUT_CYC = 64;

endpackage

// File: rtl/sqrt_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic             found_o
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      gnt_o   = '0;
      found_o = 1'b0;
      idx     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = PTR_W'((int'(ptr_i) + i) % N_REQ);
         if (!found_o && req_i[idx]) begin
            found_o    = 1'b1;
            gnt_o[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one square-root core among N_REQ clients with round-robin arbitration.
// Define SQRT_TIMEOUT_EN to add a WAIT watchdog that forces a zero result and raises err_o.
module sqrt_arbiter
   import sqrt_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = SQRT_WIDTH,
   parameter int RES_W = WIDTH / 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ*WIDTH-1:0] radicand_i,
   output logic [N_REQ-1:0]       grant_o,
   output logic [N_REQ-1:0]       done_o,
   output logic [RES_W-1:0]       result_o,
   output logic                   busy_o,
`ifdef SQRT_TIMEOUT_EN
   output logic                   err_o,
`endif
   output logic [WIDTH-1:0]       core_s_o,
   output logic                   core_doSqrt_o,
   input  logic                   core_valid_i,
   input  logic [RES_W-1:0]       core_sqrt_i
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [N_REQ-1:0]   owner_q, owner_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic [RES_W-1:0]   result_q, result_d;
   logic [N_REQ-1:0]   pick_gnt;
   logic               pick_found;
   logic [PTR_W-1:0]   win_idx;
   logic               timeout_hit;

   rr_picker #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt),
      .found_o (pick_found)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_gnt[i]) win_idx = PTR_W'(i);
      end
   end

`ifdef SQRT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) && !core_valid_i;
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         s_q      <= '0;
         result_q <= '0;
`ifdef SQRT_TIMEOUT_EN
         cnt_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         s_q      <= s_d;
         result_q <= result_d;
`ifdef SQRT_TIMEOUT_EN
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (pick_found) state_d = S_ISSUE;
         S_ISSUE:   state_d = S_WAIT;
         S_WAIT:    if (core_valid_i || timeout_hit) state_d = S_DELIVER;
         S_DELIVER: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Radicand is sampled only on the grant edge; the core sees it held until the next grant.
   always_comb begin
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      s_d      = s_q;
      result_d = result_q;
`ifdef SQRT_TIMEOUT_EN
      cnt_d    = cnt_q;
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               owner_d = pick_gnt;
               s_d     = radicand_i[win_idx*WIDTH +: WIDTH];
               ptr_d   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
            end
         end
         S_ISSUE: begin
`ifdef SQRT_TIMEOUT_EN
            cnt_d = '0;
`endif
         end
         S_WAIT: begin
            if (core_valid_i) begin
               result_d = core_sqrt_i;
            end
`ifdef SQRT_TIMEOUT_EN
            else if (timeout_hit) begin
               result_d = '0;
               err_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         S_DELIVER: begin
            owner_d = '0;
`ifdef SQRT_TIMEOUT_EN
            err_d   = 1'b0;
`endif
         end
         default: ;
      endcase
   end

   always_comb begin
      grant_o       = owner_q;
      done_o        = (state_q == S_DELIVER) ? owner_q : '0;
      core_doSqrt_o = (state_q == S_ISSUE);
      busy_o        = (state_q != S_IDLE);
      result_o      = result_q;
      core_s_o      = s_q;
`ifdef SQRT_TIMEOUT_EN
      err_o         = err_q;
`endif
   end

endmodule
